// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external storage array through a write port and
// a registered-address read port. Optional almost_full/almost_empty logic is
// compiled in with macro FIFO_CTRL_ALMOST_FLAGS_EN.
module fifo_ctrl #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int A_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [WIDTH-1:0]   push_data,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [WIDTH-1:0]   pop_data,
  output logic [A_WIDTH:0]   count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wen,
  output logic [WIDTH-1:0]   ram_wdata,
  output logic [A_WIDTH-1:0] ram_raddr,
  output logic               ram_ren,
  input  logic [WIDTH-1:0]   ram_rdata
);

  localparam logic [A_WIDTH:0]   DEPTH_C = (A_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [A_WIDTH-1:0] LAST_C  = A_WIDTH'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [A_WIDTH:0]   count_q;
  logic [A_WIDTH:0]   unfetched;
  logic               pop_valid_q;
  logic               push_fire, pop_fire, fetch, block;

  function automatic logic [A_WIDTH-1:0] ptr_inc(input logic [A_WIDTH-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // push_ready looks only at registered occupancy, so a full FIFO stays
  // closed even in a cycle where the presented word is being taken.
  assign push_ready = (count_q < DEPTH_C);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid_q & pop_ready;
  assign block      = rst | flush;

  // The presented word is still counted but already sits in the read latch.
  assign unfetched = count_q - {{A_WIDTH{1'b0}}, pop_valid_q};
  assign fetch     = (unfetched != '0) & (~pop_valid_q | pop_fire);

  assign ram_wen   = push_fire & ~block;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = push_data;
  assign ram_ren   = fetch & ~block;
  assign ram_raddr = rd_ptr;

  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_rdata;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (block) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      state       <= IDLE;
      pop_valid_q <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (fetch)     rd_ptr <= ptr_inc(rd_ptr);

      if (push_fire && !pop_fire)      count_q <= count_q + 1'b1;
      else if (pop_fire && !push_fire) count_q <= count_q - 1'b1;

      case (state)
        IDLE: begin
          if (fetch) begin
            state       <= PRESENT;
            pop_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (pop_fire && !fetch) begin
            state       <= IDLE;
            pop_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          pop_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  localparam logic [A_WIDTH:0] AF_C = (A_WIDTH+1)'(AF_LEVEL);
  localparam logic [A_WIDTH:0] AE_C = (A_WIDTH+1)'(AE_LEVEL);

  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (default WIDTH=32, FIFO_DEPTH=4) with a
// behavioral storage array attached to the ram_* port.
module tb_fifo_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic [WIDTH-1:0] push_data, pop_data, ram_wdata, ram_rdata;
  logic [AW:0]      count;
  logic             almost_full, almost_empty, ram_wen, ram_ren;
  logic [AW-1:0]    ram_waddr, ram_raddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata)
  );

  // storage: write port plus latched read address
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr_q = '0;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) raddr_q <= ram_raddr;
  end
  assign ram_rdata = mem[raddr_q];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input bit ae, input bit af);
    chk({name, ".almost_empty"}, 64'(almost_empty), 64'(FLAGS & ae));
    chk({name, ".almost_full"},  64'(almost_full),  64'(FLAGS & af));
  endtask

  typedef struct {
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic             prdy;
    logic             e_pv;
    logic [WIDTH-1:0] e_pd;
    logic [AW:0]      e_cnt;
    logic             e_prdy;
    logic             e_ae;
    logic             e_af;
  } vec_t;

  vec_t vec [12];

  initial begin
    // {push_valid, push_data, pop_ready, exp pop_valid, exp pop_data, exp count, exp push_ready, exp ae, exp af}
    vec[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,          3'd1, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 3'd1, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          3'd0, 1'b1, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 32'h1,         1'b0, 1'b0, 32'h0,          3'd1, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 32'h2,         1'b0, 1'b1, 32'h1,          3'd2, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 32'h3,         1'b0, 1'b1, 32'h1,          3'd3, 1'b1, 1'b0, 1'b1};
    vec[6]  = '{1'b1, 32'h4,         1'b0, 1'b1, 32'h1,          3'd4, 1'b0, 1'b0, 1'b1};
    vec[7]  = '{1'b1, 32'h5,         1'b0, 1'b1, 32'h1,          3'd4, 1'b0, 1'b0, 1'b1};
    // full + pop fire + push_valid: push must still be refused
    vec[8]  = '{1'b1, 32'h6,         1'b1, 1'b1, 32'h2,          3'd3, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3,          3'd2, 1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,          3'd1, 1'b1, 1'b1, 1'b0};
    vec[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          3'd0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; push_valid = 1'b1; push_data = 32'hDEAD; pop_ready = 1'b1;
    #1;
    chk("rst.ram_wen", 64'(ram_wen), 64'd0);
    chk("rst.ram_ren", 64'(ram_ren), 64'd0);
    step(); step();
    rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.pop_valid", 64'(pop_valid), 64'd0);
    chk("rst.push_ready", 64'(push_ready), 64'd1);
    chk_flags("rst", 1'b1, 1'b0);

    // push lands on ram port in the same cycle
    push_valid = vec[0].pv; push_data = vec[0].pd; pop_ready = vec[0].prdy;
    #1;
    chk("push.ram_wen", 64'(ram_wen), 64'd1);
    chk("push.ram_wdata", 64'(ram_wdata), 64'hA5A5_0001);

    for (int i = 0; i < 12; i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      push_valid = vec[i].pv; push_data = vec[i].pd; pop_ready = vec[i].prdy;
      step();
      chk({n, ".pop_valid"}, 64'(pop_valid), 64'(vec[i].e_pv));
      if (vec[i].e_pv) chk({n, ".pop_data"}, 64'(pop_data), 64'(vec[i].e_pd));
      chk({n, ".count"}, 64'(count), 64'(vec[i].e_cnt));
      chk({n, ".push_ready"}, 64'(push_ready), 64'(vec[i].e_prdy));
      chk_flags(n, vec[i].e_ae, vec[i].e_af);
    end

    // streaming 20 words with the consumer always ready
    begin
      int nxt, got;
      nxt = 0; got = 0;
      for (int e = 1; e <= 40; e++) begin
        push_valid = (nxt < 20);
        push_data  = 32'(nxt);
        pop_ready  = 1'b1;
        if (pop_valid) begin
          chk($sformatf("stream.data%0d", got), 64'(pop_data), 64'(got));
          got++;
        end
        if (push_valid && push_ready) nxt++;
        step();
        if (e >= 2 && e <= 20) chk($sformatf("stream.count@%0d", e), 64'(count), 64'd2);
        if (got > 0 && got < 20) chk($sformatf("stream.bubble@%0d", e), 64'(pop_valid), 64'd1);
        if (got == 20 && !pop_valid) break;
      end
      chk("stream.words", 64'(got), 64'd20);
      chk("stream.count_end", 64'(count), 64'd0);
    end

    // flush with three entries and a word presented
    push_valid = 1'b1; pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_data = 32'h100 + 32'(i);
      step();
    end
    push_valid = 1'b0;
    chk("flush.pre_count", 64'(count), 64'd3);
    chk("flush.pre_pop_valid", 64'(pop_valid), 64'd1);
    flush = 1'b1; push_valid = 1'b1; push_data = 32'hBAD;
    #1;
    chk("flush.ram_wen", 64'(ram_wen), 64'd0);
    chk("flush.ram_ren", 64'(ram_ren), 64'd0);
    step();
    flush = 1'b0; push_valid = 1'b0;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.pop_valid", 64'(pop_valid), 64'd0);
    push_valid = 1'b1; push_data = 32'h77;
    step();
    push_valid = 1'b0;
    step();
    chk("flush.after_pv", 64'(pop_valid), 64'd1);
    chk("flush.after_data", 64'(pop_data), 64'h77);

    // reset mid-transfer, also overriding flush
    push_valid = 1'b1; push_data = 32'h88;
    step();
    rst = 1'b1; flush = 1'b1; pop_ready = 1'b1;
    #1;
    chk("rst2.ram_wen", 64'(ram_wen), 64'd0);
    chk("rst2.ram_ren", 64'(ram_ren), 64'd0);
    step();
    rst = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    chk("rst2.count", 64'(count), 64'd0);
    chk("rst2.pop_valid", 64'(pop_valid), 64'd0);
    chk("rst2.push_ready", 64'(push_ready), 64'd1);
    chk_flags("rst2", 1'b1, 1'b0);
    step();
    chk("rst2.idle_pv", 64'(pop_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of storage entries (any value >= 2, not limited to powers of two).
REQ-003 SHALL have parameter A_WIDTH, default $clog2(FIFO_DEPTH), meaning storage address width.
REQ-004 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, meaning almost_full threshold.
REQ-005 SHALL have parameter AE_LEVEL, default 1, meaning almost_empty threshold.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state; rst  input  1  synchronous active-high reset.
REQ-007 SHALL have: flush  input  1  synchronous clear of contents; push_valid  input  1  write request; push_ready  output  1  write accepted when high; push_data  input  WIDTH  write word.
REQ-008 SHALL have: pop_valid  output  1  word presented; pop_ready  input  1  consumer takes word; pop_data  output  WIDTH  presented word.
REQ-009 SHALL have: count  output  A_WIDTH+1  occupancy including presented word; almost_full  output  1; almost_empty  output  1.
REQ-010 SHALL have storage-port signals: ram_waddr  output  A_WIDTH; ram_wen  output  1; ram_wdata  output  WIDTH; ram_raddr  output  A_WIDTH; ram_ren  output  1; ram_rdata  input  WIDTH  (storage latches ram_raddr on clk when ram_ren=1; ram_rdata reflects the latched address combinationally).

Function
REQ-011 SHALL define push fire = push_valid & push_ready, and pop fire = pop_valid & pop_ready.
REQ-012 SHALL drive push_ready = (count < FIFO_DEPTH) from registered state only; no combinational dependence on pop_ready.
REQ-013 SHALL on push fire drive ram_wen=1, ram_waddr=wr_ptr, ram_wdata=push_data in the same cycle; wr_ptr advances next edge, wrapping FIFO_DEPTH-1 -> 0.
REQ-014 SHALL keep unfetched = count - pop_valid, and issue a fetch (ram_ren=1, ram_raddr=rd_ptr) when unfetched > 0 and (pop_valid=0 or pop fire); rd_ptr advances next edge with the same wrap rule.
REQ-015 SHALL implement a two-state presentation FSM: IDLE (pop_valid=0) and PRESENT (pop_valid=1); IDLE->PRESENT on fetch; PRESENT->IDLE on pop fire without fetch; PRESENT->PRESENT on pop fire with fetch or no pop fire.
REQ-016 SHALL drive pop_data = ram_rdata; pop_data SHALL be stable while pop_valid=1 and pop_ready=0.
REQ-017 SHALL update count: +1 on push fire only, -1 on pop fire only, unchanged on both or neither.
REQ-018 SHALL have push-to-pop latency of 2 cycles into an empty FIFO: push fire in cycle N, fetch in N+1, pop_valid=1 in N+2.
REQ-019 SHALL never overwrite the presented or any unfetched entry; at count=FIFO_DEPTH push_ready=0 even when pop fire occurs that cycle.
REQ-020 SHALL ignore pop_ready while pop_valid=0 and push_valid while push_ready=0, with no state change.
REQ-021 SHALL on flush clear wr_ptr, rd_ptr, count and FSM to IDLE at next edge, suppressing ram_wen and ram_ren that cycle; flush has priority over push and pop.
REQ-022 SHALL drive almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL) when enabled.

Reset
REQ-023 SHALL on rst=1 at a clk edge set wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE; following outputs: pop_valid=0, push_ready=1, almost_empty=1 (enabled), almost_full=0.
REQ-024 SHALL drive ram_wen=0 and ram_ren=0 while rst=1; reset mid-transfer discards all contents; rst has priority over flush.

Configuration
REQ-025 SHALL compile almost_full/almost_empty logic only when macro FIFO_CTRL_ALMOST_FLAGS_EN is defined; without it both ports exist and are tied to 0, and AF_LEVEL/AE_LEVEL are unused.

Verification
REQ-026 SHALL cover: reset, push 0xA5A5_0001 in cycle 1 -> pop_valid=1 in cycle 3, pop_data=0xA5A5_0001, count=1.
REQ-027 SHALL cover: pop_ready=0, push 4 words 0x1..0x4 -> count=4, push_ready=0, 5th push (0x5) not written; pop all -> order 0x1,0x2,0x3,0x4.
REQ-028 SHALL cover: continuous push and pop_ready=1 for 20 words 0..19 -> pointer wrap, in-order data, count steady at 2 after fill, no bubbles.
REQ-029 SHALL cover: count=3, pop_valid=1, assert flush with push_valid=1 -> next cycle count=0, pop_valid=0, no ram_wen that cycle.
REQ-030 SHALL cover: FIFO_DEPTH=4, count=4, push_valid=1 and pop fire same cycle -> count=3, push not accepted.
REQ-031 SHALL cover (macro defined, AF_LEVEL=3, AE_LEVEL=1): count 0->3 -> almost_empty 1,1,0,0 and almost_full 0,0,0,1; macro undefined -> both stay 0.
